// File: rtl/reg_file_mp_pkg.sv
// Shared types and constants for the multi-read-port integer register file.
package rf_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;

    typedef enum logic {
        RF_CLEAR,
        RF_RUN
    } rf_state_t;

    function automatic int rf_aw(input int nregs);
        return $clog2(nregs);
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback-facing bus of the register file: read ports, writeback and scoreboard claims.
interface reg_file_mp_if
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2
);
    localparam int AW = rf_aw(NREGS);

    logic                init_done;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic                wen;
    logic [AW-1:0]       rd;
    logic [XLEN-1:0]     wd;
    logic                claim_en;
    logic [AW-1:0]       claim_rd;

    modport master (
        input  init_done, rs_data, rs_busy,
        output rs_addr, wen, rd, wd, claim_en, claim_rd
    );

    modport slave (
        output init_done, rs_data, rs_busy,
        input  rs_addr, wen, rd, wd, claim_en, claim_rd
    );

endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Per-register pending bits used by issue to detect RAW hazards against in-flight writebacks.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int NREGS = NREGS_DEF,
    parameter  int NRD   = 2,
    localparam int AW    = rf_aw(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en_i,
    input  logic [AW-1:0]     set_idx_i,
    input  logic              clr_en_i,
    input  logic [AW-1:0]     clr_idx_i,
    input  logic [NRD*AW-1:0] rd_addr_i,
    output logic [NRD-1:0]    busy_o
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    // Set is applied after clear so a younger claim survives an older writer retiring.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) pending_d[clr_idx_i] = 1'b0;
        if (set_en_i) pending_d[set_idx_i] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        busy_o = '0;
        for (int i = 0; i < NRD; i++) begin
            busy_o[i] = pending_q[rd_addr_i[i*AW +: AW]];
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port integer register file with post-reset clear sweep and pending scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle writeback data/busy-clear onto the read ports.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_file_mp_if.slave rf
);

    localparam int AW = rf_aw(NREGS);

    rf_state_t       state_q;
    logic [AW-1:0]   ptr_q;
    logic            init_done_q;
    logic [XLEN-1:0] regs_q [NREGS];

    logic            run;
    logic            wr_fire;
    logic            claim_fire;
    logic            mem_we;
    logic [AW-1:0]   mem_wa;
    logic [XLEN-1:0] mem_wd;
    logic [NRD-1:0]  sb_busy;

    assign run        = (state_q == RF_RUN);
    assign wr_fire    = run && rf.wen && (rf.rd != '0);
    assign claim_fire = run && rf.claim_en && (rf.claim_rd != '0);
    assign rf.init_done = init_done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RF_CLEAR;
            ptr_q       <= AW'(1);
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                RF_CLEAR: begin
                    ptr_q <= ptr_q + AW'(1);
                    if (ptr_q == AW'(NREGS - 1)) begin
                        state_q     <= RF_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The sweep owns the single write port while clearing; writebacks are dropped.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = rf.rd;
        mem_wd = rf.wd;
        if (rst_n) begin
            if (!run) begin
                mem_we = 1'b1;
                mem_wa = ptr_q;
                mem_wd = '0;
            end else if (wr_fire) begin
                mem_we = 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset term; the post-reset sweep clears it instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            regs_q[mem_wa] <= mem_wd;
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en_i  (claim_fire),
        .set_idx_i (rf.claim_rd),
        .clr_en_i  (wr_fire),
        .clr_idx_i (rf.rd),
        .rd_addr_i (rf.rs_addr),
        .busy_o    (sb_busy)
    );

    always_comb begin
        rf.rs_data = '0;
        rf.rs_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (run && (rf.rs_addr[i*AW +: AW] != '0)) begin
                rf.rs_data[i*XLEN +: XLEN] = regs_q[rf.rs_addr[i*AW +: AW]];
                rf.rs_busy[i]              = sb_busy[i];
            end
`ifdef REG_FILE_BYPASS_EN
            if (wr_fire && (rf.rs_addr[i*AW +: AW] == rf.rd)) begin
                rf.rs_data[i*XLEN +: XLEN] = rf.wd;
                rf.rs_busy[i]              = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: default 2-port/32-reg instance plus a 4-port/16-reg instance.
module tb_reg_file_mp;
    import rf_pkg::*;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    reg_file_mp_if #(.XLEN(64), .NREGS(32), .NRD(2)) a_if ();
    reg_file_mp_if #(.XLEN(64), .NREGS(16), .NRD(4)) b_if ();

    reg_file_mp #(.XLEN(64), .NREGS(32), .NRD(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (a_if)
    );

    reg_file_mp #(.XLEN(64), .NREGS(16), .NRD(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (b_if)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        a_if.wen = 1'b0; a_if.rd = '0; a_if.wd = '0;
        a_if.claim_en = 1'b0; a_if.claim_rd = '0;
        b_if.wen = 1'b0; b_if.rd = '0; b_if.wd = '0;
        b_if.claim_en = 1'b0; b_if.claim_rd = '0;
    endtask

    // Counts rising edges until each instance raises init_done (0 if it never does).
    task automatic run_sweep(output int na, output int nb);
        int n = 0;
        na = 0;
        nb = 0;
        while (n < 100 && !(a_if.init_done && b_if.init_done)) begin
            tick();
            n++;
            if (a_if.init_done && na == 0) na = n;
            if (b_if.init_done && nb == 0) nb = n;
        end
    endtask

    task automatic test_reset;
        logic [63:0] obs[$];
        exp_t e;
        int na, nb;
        idle_inputs();
        a_if.rs_addr = {5'd0, 5'd5};
        b_if.rs_addr = '0;
        rst_n = 1'b0;
        tick();
        tick();
        exp_q.push_back('{"rst_init_done_a", 64'd0}); obs.push_back({63'd0, a_if.init_done});
        exp_q.push_back('{"rst_busy_a", 64'd0});      obs.push_back({62'd0, a_if.rs_busy});
        exp_q.push_back('{"rst_data_a0", 64'd0});     obs.push_back(a_if.rs_data[63:0]);
        exp_q.push_back('{"rst_init_done_b", 64'd0}); obs.push_back({63'd0, b_if.init_done});
        rst_n = 1'b1;
        run_sweep(na, nb);
        exp_q.push_back('{"sweep_edges_32", 64'd31}); obs.push_back(64'(na));
        exp_q.push_back('{"sweep_edges_16", 64'd15}); obs.push_back(64'(nb));
        for (int a = 1; a < 32; a++) begin
            a_if.rs_addr = {5'(a), 5'(a)};
            #1;
            exp_q.push_back('{"cleared_p0", 64'd0}); obs.push_back(a_if.rs_data[63:0]);
            exp_q.push_back('{"cleared_p1", 64'd0}); obs.push_back(a_if.rs_data[127:64]);
        end
        for (int k = 0; k < obs.size(); k++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs[k] !== e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%h, want 0x%h", e.tag, obs[k], e.exp);
            end
        end
    endtask

    task automatic test_write_read;
        logic [63:0] obs[$];
        exp_t e;
        a_if.wen = 1'b1; a_if.rd = 5'd5; a_if.wd = 64'hA5A5_A5A5_A5A5_A5A5;
        tick();
        a_if.rd = 5'd0; a_if.wd = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        idle_inputs();
        a_if.rs_addr = {5'd0, 5'd5};
        #1;
        exp_q.push_back('{"wr_x5_p0", 64'hA5A5_A5A5_A5A5_A5A5}); obs.push_back(a_if.rs_data[63:0]);
        exp_q.push_back('{"wr_x0_p1", 64'd0});                   obs.push_back(a_if.rs_data[127:64]);
        a_if.rs_addr = {5'd5, 5'd0};
        #1;
        exp_q.push_back('{"wr_x0_p0", 64'd0});                   obs.push_back(a_if.rs_data[63:0]);
        exp_q.push_back('{"wr_x5_p1", 64'hA5A5_A5A5_A5A5_A5A5}); obs.push_back(a_if.rs_data[127:64]);
        for (int k = 0; k < obs.size(); k++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs[k] !== e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%h, want 0x%h", e.tag, obs[k], e.exp);
            end
        end
    endtask

    task automatic test_bypass;
        logic [63:0] obs[$];
        exp_t e;
        a_if.wen = 1'b1; a_if.rd = 5'd6; a_if.wd = 64'h1111;
        a_if.claim_en = 1'b1; a_if.claim_rd = 5'd6;
        tick();
        a_if.claim_en = 1'b0;
        a_if.wd = 64'h1234_5678_9ABC_DEF0;
        a_if.rs_addr = {5'd0, 5'd6};
        #1;
`ifdef REG_FILE_BYPASS_EN
        exp_q.push_back('{"byp_pre_data", 64'h1234_5678_9ABC_DEF0});
        exp_q.push_back('{"byp_pre_busy", 64'd0});
`else
        exp_q.push_back('{"byp_pre_data", 64'h1111});
        exp_q.push_back('{"byp_pre_busy", 64'd1});
`endif
        obs.push_back(a_if.rs_data[63:0]);
        obs.push_back({63'd0, a_if.rs_busy[0]});
        tick();
        idle_inputs();
        #1;
        exp_q.push_back('{"byp_post_data", 64'h1234_5678_9ABC_DEF0}); obs.push_back(a_if.rs_data[63:0]);
        exp_q.push_back('{"byp_post_busy", 64'd0});                   obs.push_back({63'd0, a_if.rs_busy[0]});
        for (int k = 0; k < obs.size(); k++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs[k] !== e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%h, want 0x%h", e.tag, obs[k], e.exp);
            end
        end
    endtask

    task automatic test_scoreboard;
        logic [63:0] obs[$];
        exp_t e;
        a_if.claim_en = 1'b1; a_if.claim_rd = 5'd7;
        a_if.rs_addr = {5'd7, 5'd0};
        #1;
        exp_q.push_back('{"sb_pre_claim", 64'd0}); obs.push_back({63'd0, a_if.rs_busy[1]});
        tick();
        idle_inputs();
        #1;
        exp_q.push_back('{"sb_claimed", 64'd1}); obs.push_back({63'd0, a_if.rs_busy[1]});
        a_if.wen = 1'b1; a_if.rd = 5'd7; a_if.wd = 64'h42;
        tick();
        idle_inputs();
        #1;
        exp_q.push_back('{"sb_wr_busy", 64'd0}); obs.push_back({63'd0, a_if.rs_busy[1]});
        exp_q.push_back('{"sb_wr_data", 64'h42}); obs.push_back(a_if.rs_data[127:64]);
        a_if.wen = 1'b1; a_if.rd = 5'd7; a_if.wd = 64'h99;
        a_if.claim_en = 1'b1; a_if.claim_rd = 5'd7;
        tick();
        idle_inputs();
        #1;
        exp_q.push_back('{"sb_same_busy", 64'd1}); obs.push_back({63'd0, a_if.rs_busy[1]});
        exp_q.push_back('{"sb_same_data", 64'h99}); obs.push_back(a_if.rs_data[127:64]);
        a_if.claim_en = 1'b1; a_if.claim_rd = 5'd0;
        a_if.rs_addr = {5'd0, 5'd0};
        tick();
        idle_inputs();
        #1;
        exp_q.push_back('{"sb_x0_busy", 64'd0}); obs.push_back({63'd0, a_if.rs_busy[1]});
        a_if.wen = 1'b1; a_if.rd = 5'd7; a_if.wd = 64'h99;
        tick();
        idle_inputs();
        for (int k = 0; k < obs.size(); k++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs[k] !== e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%h, want 0x%h", e.tag, obs[k], e.exp);
            end
        end
    endtask

    task automatic test_multi_port;
        logic [63:0] obs[$];
        exp_t e;
        b_if.wen = 1'b1; b_if.rd = 4'd3; b_if.wd = 64'hDEAD;
        tick();
        idle_inputs();
        b_if.rs_addr = {4'd3, 4'd3, 4'd3, 4'd3};
        #1;
        for (int p = 0; p < 4; p++) begin
            exp_q.push_back('{"mp_x3_port", 64'hDEAD});
            obs.push_back(b_if.rs_data[p*64 +: 64]);
        end
        for (int k = 0; k < obs.size(); k++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs[k] !== e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%h, want 0x%h", e.tag, obs[k], e.exp);
            end
        end
    endtask

    task automatic test_reset_mid_op;
        logic [63:0] obs[$];
        exp_t e;
        int na, nb;
        a_if.claim_en = 1'b1; a_if.claim_rd = 5'd9;
        tick();
        idle_inputs();
        a_if.rs_addr = {5'd5, 5'd9};
        #1;
        exp_q.push_back('{"mid_pre_busy9", 64'd1}); obs.push_back({63'd0, a_if.rs_busy[0]});
        exp_q.push_back('{"mid_pre_x5", 64'hA5A5_A5A5_A5A5_A5A5}); obs.push_back(a_if.rs_data[127:64]);
        rst_n = 1'b0;
        a_if.wen = 1'b1; a_if.rd = 5'd5; a_if.wd = 64'h77;
        tick();
        rst_n = 1'b1;
        idle_inputs();
        #1;
        exp_q.push_back('{"mid_init_done", 64'd0}); obs.push_back({63'd0, a_if.init_done});
        exp_q.push_back('{"mid_busy", 64'd0});      obs.push_back({62'd0, a_if.rs_busy});
        exp_q.push_back('{"mid_data_x5", 64'd0});   obs.push_back(a_if.rs_data[127:64]);
        run_sweep(na, nb);
        exp_q.push_back('{"mid_sweep_32", 64'd31}); obs.push_back(64'(na));
        exp_q.push_back('{"mid_sweep_16", 64'd15}); obs.push_back(64'(nb));
        #1;
        exp_q.push_back('{"mid_post_x5", 64'd0});    obs.push_back(a_if.rs_data[127:64]);
        exp_q.push_back('{"mid_post_busy9", 64'd0}); obs.push_back({63'd0, a_if.rs_busy[0]});
        for (int k = 0; k < obs.size(); k++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs[k] !== e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%h, want 0x%h", e.tag, obs[k], e.exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_multi_port();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port integer register file for the 64-bit RISC-V core, replacing the fixed two-read/one-write file. It keeps x0 hard-wired to zero. It adds a post-reset clear sweep, an optional same-cycle write-to-read bypass, and a per-register pending scoreboard. The decode/issue stage uses the scoreboard to detect RAW hazards against in-flight writebacks. It sits between decode (reads, claims) and writeback (writes).

## Interface
- XLEN, 64, data width in bits
- NREGS, 32, architectural register count (power of two, ≥ 4)
- NRD, 2, number of read ports (1..4)
- AW is derived as clog2(NREGS); it is not overridable.
- clk  in  1  rising-edge clock; the block's single clock
- rst_n  in  1  reset, synchronous and active-low
- init_done  out  1  high once the clear sweep has finished
- rs_addr  in  NRD*AW  read addresses; port i is [i*AW +: AW]
- rs_data  out  NRD*XLEN  read data; port i is [i*XLEN +: XLEN]
- rs_busy  out  NRD  pending flag of each read address
- wen  in  1  writeback enable
- rd  in  AW  writeback destination
- wd  in  XLEN  writeback data
- claim_en  in  1  issue stage marks a destination as pending
- claim_rd  in  AW  register being claimed

## Operation
- States are RF_CLEAR and RF_RUN.
- Reset handling, on any edge with rst_n=0:
  - state goes to RF_CLEAR, sweep pointer goes to 1, all pending bits clear, init_done goes to 0.
  - Register contents are not touched on that edge.
- RF_CLEAR behaviour:
  - Each edge with rst_n=1 writes 0 to reg[ptr] and increments ptr.
  - On the edge that clears reg[NREGS-1], state goes to RF_RUN.
  - wen and claim_en are ignored throughout.
  - rs_data reads 0 and rs_busy reads 0 throughout.
- RF_RUN behaviour:
  - Reads are combinational: rs_data[i] = reg[rs_addr[i]], or 0 when rs_addr[i]=0.
  - A write with wen=1 and rd≠0 updates reg[rd] at the edge and clears pending[rd].
  - A write to rd=0 is discarded.
  - claim_en=1 with claim_rd≠0 sets pending[claim_rd] at the edge.
  - claim_rd=0 is ignored; pending[0] is permanently 0.
  - If a claim and a write target the same register on the same edge, the claim wins: pending ends at 1, and the data write still happens. This models a younger writer issuing while the older one retires.
  - rs_busy[i] = pending[rs_addr[i]].
- Multiple read ports may address the same register; each returns identical data.
- Reset mid-sweep or mid-run restarts the sweep from ptr=1 and drops all pending state. In-flight writes on the reset edge are lost.

## Timing
- Reset values: init_done=0, rs_busy=0, rs_data=0 (forced while in RF_CLEAR).
- Sweep length: with NREGS=32, init_done rises after the 31st rising edge with rst_n=1 following reset release. In general it takes NREGS-1 edges.
- Write-to-read latency:
  - without bypass, 1 cycle; the value is visible after the write edge.
  - with bypass, 0 cycles (see Configuration).
- Claim-to-busy latency: 1 cycle. Write-to-busy-clear: 1 cycle without bypass, 0 cycles with bypass.
- The read path is combinational (no read latency). The write and scoreboard paths are registered.

## Configuration
- REG_FILE_BYPASS_EN defined:
  - In RF_RUN, when wen=1, rd≠0 and rs_addr[i]=rd, rs_data[i] returns wd in the same cycle.
  - In the same condition, rs_busy[i] is forced 0 in the same cycle.
- REG_FILE_BYPASS_EN undefined:
  - Reads return the stored value, and rs_busy reflects the registered pending bit.
  - Writeback data becomes visible only after the write edge.

## Structure
- Package rf_pkg holds:
  - the XLEN default constant and the NREGS default constant;
  - the typedef enum rf_state_t {RF_CLEAR, RF_RUN};
  - the AW helper function.
- Sub-module rf_scoreboard holds the NREGS-bit pending vector, its set/clear priority logic and the NRD busy lookups.
- The storage array, sweep FSM and read muxing stay in reg_file_mp.

## Test plan
- Sweep after reset: hold rst_n=0 for 2 edges, release, count edges until init_done=1. Required: 31 edges; every port reads 0 for addresses 1..31.
- Write, then read: write x5=0xA5A5A5A5A5A5A5A5, then attempt x0=0xFFFFFFFFFFFFFFFF. Read ports 0/1 at addresses 5/0. Required: 0xA5A5A5A5A5A5A5A5 and 0.
- Bypass (both builds): wen=1, rd=6, wd=0x123456789ABCDEF0, rs_addr[0]=6, sampled before the edge.
  - With REG_FILE_BYPASS_EN: returns 0x1234…DEF0 and rs_busy[0]=0.
  - Without it: returns the old value, and the new value appears after the edge.
- Scoreboard:
  - claim x7, then read port 1 at 7: rs_busy[1]=1 after 1 edge.
  - write x7=0x42: busy 0 afterwards.
  - claim x7 and write x7 on the same edge: busy stays 1 and reg[7] updates.
- Reset mid-operation: after x5 is written and x9 is claimed, pulse rst_n low for 1 edge.
  - Required: init_done=0, rs_busy=0, and a fresh 31-edge sweep.
  - Afterwards x5 reads 0.
- NRD=4, NREGS=16 configuration: all 4 ports read the same x3=0xDEAD simultaneously. Required: all return 0xDEAD, and init_done rises after 15 edges.
